// File: rtl/pipeline_trace_buffer_pkg.sv
// Shared types for the pipeline trace buffer: capture states and trigger modes.
package pipeline_trace_buffer_pkg;

  localparam int PC_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    TRIG_PC   = 2'd0,
    TRIG_BR   = 2'd1,
    TRIG_DATA = 2'd2,
    TRIG_IMM  = 2'd3
  } trig_mode_e;

endpackage

// File: rtl/pipeline_trace_buffer_if.sv
// Probe bus from the core's pipeline taps into the trace buffer.
interface pipeline_trace_buffer_if #(
  parameter int TRACE_W = 64
);
  import pipeline_trace_buffer_pkg::*;

  logic               valid;
  logic [PC_W-1:0]    pc;
  logic [TRACE_W-1:0] data;
  logic               branch;

  modport master (output valid, pc, data, branch);
  modport slave  (input  valid, pc, data, branch);

endinterface

// File: rtl/pipeline_trace_buffer_ram.sv
// Simple dual-port trace storage: one write port, registered read port, no reset.
module pipeline_trace_buffer_ram #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 129,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [PTR_W-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write the captured entry and register the read word every cycle.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/pipeline_trace_buffer.sv
// Trace capture: circular buffer of {pc, data, branch}, trigger-relative stop, random-access readout.
module pipeline_trace_buffer
  import pipeline_trace_buffer_pkg::*;
#(
  parameter int TRACE_W = 64,
  parameter int DEPTH   = 32,
  parameter int PTR_W   = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  pipeline_trace_buffer_if.slave probe,
  input  logic                 arm,
  input  logic [1:0]           trig_mode,
  input  logic [PC_W-1:0]      trig_value,
  input  logic [PTR_W-1:0]     post_count,
  input  logic [PTR_W-1:0]     rd_idx,
  output logic [PC_W-1:0]      rd_pc,
  output logic [TRACE_W-1:0]   rd_data,
  output logic                 rd_branch,
  output logic [1:0]           state,
  output logic                 done,
  output logic [PTR_W:0]       count,
  output logic [PTR_W-1:0]     trig_pos
);

  localparam int ENTRY_W = PC_W + TRACE_W + 1;

  state_e             state_q;
  state_e             state_d;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   post_left;
  logic [PTR_W-1:0]   trig_phys;
  logic [PTR_W-1:0]   start_ptr;
  logic [PTR_W-1:0]   rd_phys;
  logic               wrapped;
  logic               arm_accept;
  logic               write_en;
  logic               trig_hit;
  logic               rd_live;
  logic [ENTRY_W-1:0] ram_q;

  assign arm_accept = arm && (state_q == ST_IDLE || state_q == ST_DONE);
  assign write_en   = probe.valid && (state_q == ST_ARMED || state_q == ST_POST);

  // Trigger condition for the sample currently on the probe bus.
  always_comb begin
    trig_hit = 1'b0;
    case (trig_mode_e'(trig_mode))
      TRIG_PC:   trig_hit = (probe.pc == trig_value);
      TRIG_BR:   trig_hit = probe.branch;
      TRIG_DATA: trig_hit = (probe.data == trig_value[TRACE_W-1:0]);
      default:   trig_hit = 1'b1;
    endcase
  end

  // Capture state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: arm restarts from idle/done, trigger ends pre-history, post countdown ends capture.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: if (arm) state_d = ST_ARMED;
      ST_ARMED: begin
        if (probe.valid && trig_hit) begin
          state_d = (post_left == '0) ? ST_DONE : ST_POST;
        end
      end
      ST_POST: begin
        if (probe.valid && post_left == PTR_W'(1)) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Write pointer, wrap flag, post-trigger countdown and trigger location.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      wrapped   <= 1'b0;
      post_left <= '0;
      trig_phys <= '0;
    end else if (arm_accept) begin
      wr_ptr    <= '0;
      wrapped   <= 1'b0;
      post_left <= post_count;
      trig_phys <= '0;
    end else if (write_en) begin
      wr_ptr <= wr_ptr + PTR_W'(1);
      if (wr_ptr == PTR_W'(DEPTH - 1)) wrapped <= 1'b1;
      if (state_q == ST_ARMED && trig_hit) trig_phys <= wr_ptr;
      if (state_q == ST_POST) post_left <= post_left - PTR_W'(1);
    end
  end

  // Readout output is held at zero until the first clock after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_live <= 1'b0;
    end else begin
      rd_live <= 1'b1;
    end
  end

  assign start_ptr = wrapped ? wr_ptr : '0;
  assign rd_phys   = start_ptr + rd_idx;
  assign trig_pos  = trig_phys - start_ptr;
  assign count     = wrapped ? (PTR_W + 1)'(DEPTH) : {1'b0, wr_ptr};
  assign state     = state_q;
  assign done      = (state_q == ST_DONE);

  assign {rd_pc, rd_data, rd_branch} = rd_live ? ram_q : '0;

  pipeline_trace_buffer_ram #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W),
    .PTR_W (PTR_W)
  ) u_trace_ram (
    .clk   (clk),
    .we    (write_en),
    .waddr (wr_ptr),
    .wdata ({probe.pc, probe.data, probe.branch}),
    .raddr (rd_phys),
    .rdata (ram_q)
  );

endmodule

// File: tb/tb_pipeline_trace_buffer.sv
// Directed bench for pipeline_trace_buffer with a behavioural capture model and readout scoreboard.
module tb_pipeline_trace_buffer;
  import pipeline_trace_buffer_pkg::*;

  localparam int DEPTH   = 8;
  localparam int TRACE_W = 64;
  localparam int PTR_W   = $clog2(DEPTH);

  typedef struct packed {
    logic [63:0]        pc;
    logic [TRACE_W-1:0] data;
    logic               branch;
  } sample_t;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               arm = 1'b0;
  logic [1:0]         trig_mode = 2'd0;
  logic [63:0]        trig_value = '0;
  logic [PTR_W-1:0]   post_count = '0;
  logic [PTR_W-1:0]   rd_idx = '0;
  logic [63:0]        rd_pc;
  logic [TRACE_W-1:0] rd_data;
  logic               rd_branch;
  logic [1:0]         state;
  logic               done;
  logic [PTR_W:0]     count;
  logic [PTR_W-1:0]   trig_pos;

  int vectors = 0;
  int miscompares = 0;

  sample_t mHist[$];
  sample_t rdQ[$];
  int      mState = 0;
  int      mPostLeft = 0;
  int      mTotal = 0;
  int      mTrigAbs = 0;

  pipeline_trace_buffer_if #(.TRACE_W(TRACE_W)) probe_bus ();

  pipeline_trace_buffer #(
    .TRACE_W (TRACE_W),
    .DEPTH   (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .probe      (probe_bus.slave),
    .arm        (arm),
    .trig_mode  (trig_mode),
    .trig_value (trig_value),
    .post_count (post_count),
    .rd_idx     (rd_idx),
    .rd_pc      (rd_pc),
    .rd_data    (rd_data),
    .rd_branch  (rd_branch),
    .state      (state),
    .done       (done),
    .count      (count),
    .trig_pos   (trig_pos)
  );

  // Free-running 10-time-unit clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic modelPush();
    sample_t s;
    s.pc = probe_bus.pc;
    s.data = probe_bus.data;
    s.branch = probe_bus.branch;
    mHist.push_back(s);
    mTotal++;
    if (mHist.size() > DEPTH) void'(mHist.pop_front());
  endtask

  task automatic modelEdge();
    bit hit;
    case (mState)
      0, 3: begin
        if (arm) begin
          mState = 1;
          mHist.delete();
          mTotal = 0;
          mTrigAbs = 0;
          mPostLeft = int'(post_count);
        end
      end
      1: begin
        if (probe_bus.valid) begin
          case (trig_mode)
            2'd0:    hit = (probe_bus.pc == trig_value);
            2'd1:    hit = probe_bus.branch;
            2'd2:    hit = (probe_bus.data == trig_value);
            default: hit = 1'b1;
          endcase
          modelPush();
          if (hit) begin
            mTrigAbs = mTotal - 1;
            mState = (mPostLeft == 0) ? 3 : 2;
          end
        end
      end
      default: begin
        if (probe_bus.valid) begin
          modelPush();
          mPostLeft--;
          if (mPostLeft == 0) mState = 3;
        end
      end
    endcase
  endtask

  task automatic tick();
    sample_t e;
    modelEdge();
    @(posedge clk);
    #1;
    if (rdQ.size() > 0) begin
      e = rdQ.pop_front();
      checkOutput("rd_pc", rd_pc, e.pc);
      checkOutput("rd_data", rd_data, e.data);
      checkOutput("rd_branch", {63'd0, rd_branch}, {63'd0, e.branch});
    end
  endtask

  task automatic applyStimulus(input logic [63:0] pc, input logic [63:0] data, input logic br);
    probe_bus.valid = 1'b1;
    probe_bus.pc = pc;
    probe_bus.data = data;
    probe_bus.branch = br;
    tick();
    probe_bus.valid = 1'b0;
  endtask

  task automatic readIdx(input int i);
    rd_idx = PTR_W'(i);
    if (i < mHist.size()) rdQ.push_back(mHist[i]);
    tick();
  endtask

  task automatic checkModel(input string tag);
    checkOutput({tag, "_state"}, {62'd0, state}, 64'(mState));
    checkOutput({tag, "_done"}, {63'd0, done}, {63'd0, mState == 3});
    checkOutput({tag, "_count"}, 64'(count), 64'(mHist.size()));
    if (mState == 3) begin
      checkOutput({tag, "_trig_pos"}, 64'(trig_pos), 64'(mTrigAbs - (mTotal - mHist.size())));
    end
  endtask

  task automatic armCapture(input logic [1:0] mode, input logic [63:0] tv, input int post);
    trig_mode = mode;
    trig_value = tv;
    post_count = PTR_W'(post);
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  initial begin
    probe_bus.valid = 1'b0;
    probe_bus.pc = '0;
    probe_bus.data = '0;
    probe_bus.branch = 1'b0;

    #12;
    checkOutput("rst_state", {62'd0, state}, 64'd0);
    checkOutput("rst_count", 64'(count), 64'd0);
    checkOutput("rst_trig_pos", 64'(trig_pos), 64'd0);
    checkOutput("rst_rd_pc", rd_pc, 64'd0);
    reset = 1'b1;
    tick();

    $display("[TB] immediate trigger, post_count=3");
    armCapture(2'd3, 64'd0, 3);
    checkModel("t2_armed");
    for (int k = 0; k < 4; k++) applyStimulus(64'h100 + 64'(4 * k), 64'hA000 + 64'(k), 1'b0);
    checkModel("t2_done");
    checkOutput("t2_count_const", 64'(count), 64'd4);
    readIdx(1);
    checkOutput("t2_rd1_const", rd_pc, 64'h104);

    $display("[TB] pc match with wrap, post_count=2");
    armCapture(2'd0, 64'h40, 2);
    for (int k = 0; k < 20; k++) begin
      applyStimulus(64'(4 * k), 64'h1111 * 64'(k), k[0]);
      if (k == 17) checkModel("t3_post");
    end
    checkModel("t3_done");
    checkOutput("t3_count_const", 64'(count), 64'd8);
    checkOutput("t3_trig_pos_const", 64'(trig_pos), 64'd5);
    readIdx(0);
    checkOutput("t3_rd0_const", rd_pc, 64'h2C);
    readIdx(7);
    checkOutput("t3_rd7_const", rd_pc, 64'h48);

    $display("[TB] readout latency sweep");
    for (int i = 0; i < DEPTH; i++) readIdx(i);
    for (int i = DEPTH - 1; i >= 0; i -= 3) readIdx(i);

    $display("[TB] branch trigger with gaps, post_count=0");
    armCapture(2'd1, 64'd0, 0);
    applyStimulus(64'h200, 64'h1, 1'b0);
    tick();
    applyStimulus(64'h204, 64'h2, 1'b0);
    tick();
    tick();
    applyStimulus(64'h208, 64'h3, 1'b1);
    checkModel("t4_done");
    checkOutput("t4_trig_pos_const", 64'(trig_pos), 64'd2);
    applyStimulus(64'h20C, 64'h4, 1'b1);
    checkModel("t4_frozen");
    readIdx(2);

    $display("[TB] data match with arm held through ARMED");
    trig_mode = 2'd2;
    trig_value = 64'hDEAD;
    post_count = PTR_W'(1);
    arm = 1'b1;
    applyStimulus(64'h300, 64'hDEAD, 1'b0);
    checkModel("t5_arm_discard");
    applyStimulus(64'h304, 64'h5, 1'b0);
    applyStimulus(64'h308, 64'h6, 1'b1);
    checkModel("t5_arm_held");
    arm = 1'b0;
    applyStimulus(64'h30C, 64'hDEAD, 1'b0);
    checkModel("t5_post");
    applyStimulus(64'h310, 64'h7, 1'b0);
    checkModel("t5_done");
    readIdx(2);
    armCapture(2'd3, 64'd0, 5);
    checkModel("t5_rearm");

    $display("[TB] reset during POST");
    applyStimulus(64'h400, 64'h8, 1'b0);
    applyStimulus(64'h404, 64'h9, 1'b0);
    checkModel("t1_post");
    readIdx(1);
    #2;
    reset = 1'b0;
    mState = 0;
    mHist.delete();
    mTotal = 0;
    rdQ.delete();
    #1;
    checkOutput("t1_state", {62'd0, state}, 64'd0);
    checkOutput("t1_count", 64'(count), 64'd0);
    checkOutput("t1_done", {63'd0, done}, 64'd0);
    @(posedge clk);
    #1;
    checkOutput("t1_rd_pc", rd_pc, 64'd0);
    checkOutput("t1_rd_data", rd_data, 64'd0);
    reset = 1'b1;
    tick();
    checkModel("t1_idle");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
